shift_sequencer: RTL and testbench

Sequential controller that sits directly upstream of the combinational 8-bit shifter and closes a register loop around it. It accepts an operand, a 3-bit shift opcode and a step count over a valid/ready handshake. It drives the shifter's `select`/`data_in` and captures the shifter's `data_out` once per cycle for the requested number of steps. The final value is presented on a valid/ready output handshake.

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shift_sequencer.sv | 78 +++++++
 tb/tb_shift_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and default widths for the shift sequencer and its shifter.
package shift_pkg;

  localparam int DATA_W = 8;
  localparam int STEP_W = 4;

  // Shifter opcodes, applied once per pass of the combinational shifter.
  typedef enum logic [2:0] {
    NOP  = 3'd0,
    SHL  = 3'd1,
    SHR  = 3'd2,
    ROL  = 3'd3,
    ROR  = 3'd4,
    ASR  = 3'd5,
    ROL3 = 3'd6,
    ASR5 = 3'd7
  } shift_op_e;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // True when the remaining-step count marks the final shifter pass.
  function automatic logic is_last_step(input logic [STEP_W-1:0] cnt);
    return cnt == STEP_W'(1);
  endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Closes a register loop around an external combinational shifter: accepts
// an operand/opcode/step count, applies the shifter once per cycle for the
// requested number of passes, and presents the result on a valid/ready port.
module shift_sequencer #(
  parameter int DATA_W = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_op,
  input  logic [STEP_W-1:0] in_steps,
  output logic [2:0]        shf_select,
  output logic [DATA_W-1:0] shf_data_in,
  input  logic [DATA_W-1:0] shf_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  import shift_pkg::*;

  seq_state_e        state_q;
  logic [DATA_W-1:0] acc_q;
  logic [2:0]        op_q;
  logic [STEP_W-1:0] cnt_q;

  // Control FSM plus the accumulator, opcode and remaining-step registers.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would let acc_q/cnt_q race against state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q   <= in_data;
            op_q    <= in_op;
            cnt_q   <= in_steps;
            // A zero-step request skips RUN so cnt_q never enters RUN at 0.
            state_q <= (in_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          acc_q <= shf_data_out;
          cnt_q <= cnt_q - STEP_W'(1);
          if (STEP_W == 4 ? is_last_step(cnt_q) : (cnt_q == STEP_W'(1))) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and shifter-control outputs depend on registered state only,
  // so neither in_valid nor out_ready reaches an output combinationally.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  // Outside RUN the shifter is held in pass-through.
  assign shf_select  = (state_q == RUN) ? op_q : 3'b000;
  assign shf_data_in = acc_q;
  assign out_data    = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shifter closing the loop.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_op = '0;
  logic [3:0] in_steps = '0;
  logic [2:0] shf_select;
  logic [7:0] shf_data_in;
  logic [7:0] shf_data_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.DATA_W(8), .STEP_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_op       (in_op),
    .in_steps    (in_steps),
    .shf_select  (shf_select),
    .shf_data_in (shf_data_in),
    .shf_data_out(shf_data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  // Reference combinational shifter, one pass per select code.
  always_comb begin
    shf_data_out = shf_data_in;
    case (shf_select)
      3'd0: shf_data_out = shf_data_in;
      3'd1: shf_data_out = {shf_data_in[6:0], 1'b0};
      3'd2: shf_data_out = {1'b0, shf_data_in[7:1]};
      3'd3: shf_data_out = {shf_data_in[6:0], shf_data_in[7]};
      3'd4: shf_data_out = {shf_data_in[0], shf_data_in[7:1]};
      3'd5: shf_data_out = {shf_data_in[7], shf_data_in[7:1]};
      3'd6: shf_data_out = {shf_data_in[4:0], shf_data_in[7:5]};
      3'd7: shf_data_out = {{5{shf_data_in[7]}}, shf_data_in[7:5]};
      default: shf_data_out = shf_data_in;
    endcase
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    end
    vectors++;
    if ({out_data, shf_data_in, shf_select} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_data got out=%h din=%h sel=%0d want 0", out_data, shf_data_in, shf_select);
    end
  endtask

  // Issue one request (caller is at edge+1 in IDLE), wait for the result,
  // check latency/select/data, then complete the output handshake.
  task automatic run_req(input logic [7:0] data, input logic [2:0] op,
                         input logic [3:0] steps, input logic [7:0] exp,
                         input string name);
    int   cyc;
    logic sel_bad;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready got %b want 1", name, in_ready);
    end
    in_valid = 1'b1;
    in_data  = data;
    in_op    = op;
    in_steps = steps;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    sel_bad = 1'b0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (shf_select !== op || busy !== 1'b1 || in_ready !== 1'b0) sel_bad = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    vectors++;
    if (cyc !== int'(steps)) begin
      miscompares++;
      $display("FAIL %s_latency got %0d edges want %0d", name, cyc, steps);
    end
    vectors++;
    if (sel_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_run_ctrl got bad select/busy/ready during RUN want op=%0d", name, op);
    end
    vectors++;
    if (out_data !== exp || shf_select !== 3'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_result got data=%h sel=%0d busy=%b want data=%h sel=0 busy=1",
               name, out_data, shf_select, busy, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL %s_release got vld/rdy/busy=%b want 010", name, {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_shift_ops();
    run_req(8'h81, 3'd1, 4'd3, 8'h08, "shl3");
    run_req(8'hA5, 3'd3, 4'd8, 8'hA5, "rol8");
    run_req(8'h80, 3'd7, 4'd1, 8'hFC, "asr5");
    run_req(8'h3C, 3'd2, 4'd0, 8'h3C, "zero_steps");
    run_req(8'h5A, 3'd0, 4'd15, 8'h5A, "nop15");
  endtask

  task automatic test_back_to_back();
    run_req(8'h80, 3'd5, 4'd3, 8'hF0, "asr3");
    run_req(8'h01, 3'd6, 4'd2, 8'h40, "rol3x2");
  endtask

  task automatic test_stall();
    int   bad;
    in_valid = 1'b1;
    in_data  = 8'h96;
    in_op    = 3'd4;
    in_steps = 4'd1;
    @(posedge clk);
    #1;
    // Second request is presented and held during the stall.
    in_data  = 8'h11;
    in_op    = 3'd1;
    in_steps = 4'd0;
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'h4B || in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (bad !== 0 || out_data !== 8'h4B) begin
      miscompares++;
      $display("FAIL stall_hold got %0d bad cycles data=%h want 0 bad data=4b", bad, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_idle got rdy/vld=%b want 10", {in_ready, out_valid});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      miscompares++;
      $display("FAIL stall_second got vld=%b data=%h want 1/11", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int seen_valid;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_op    = 3'd2;
    in_steps = 4'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100 || {out_data, shf_data_in, shf_select} !== 19'd0) begin
      miscompares++;
      $display("FAIL async_reset got rdy/vld/busy=%b out=%h sel=%0d want 100/00/0",
               {in_ready, out_valid, busy}, out_data, shf_select);
    end
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) rst_n = 1'b1;
      if (out_valid === 1'b1) seen_valid++;
    end
    vectors++;
    if (seen_valid !== 0) begin
      miscompares++;
      $display("FAIL reset_no_result got %0d valid cycles want 0", seen_valid);
    end
    run_req(8'hF0, 3'd2, 4'd2, 8'h3C, "after_reset");
  endtask

  initial begin
    test_reset();
    test_shift_ops();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
